// File: rtl/bisr_pkg.sv
// Shared BISR definitions: spare-slot state encoding and index-width helper.
package bisr_pkg;

  // Slot state as {alloc, fault}; any state with fault set is FAULTY.
  typedef enum logic [1:0] {
    SLOT_FREE   = 2'b00,
    SLOT_ALLOC  = 2'b10,
    SLOT_FAULTY = 2'b01
  } slot_state_e;

  // Index width for n slots, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/find_first_set.sv
// Combinational priority finder: first set bit from the LSB or the MSB side.
module find_first_set #(
  parameter int unsigned WIDTH     = 16,
  parameter bit          LSB_FIRST = 1'b1,
  parameter int unsigned IDX_W     = 4
) (
  input  logic [WIDTH-1:0] vec,
  output logic             found_c,
  output logic [IDX_W-1:0] idx_c
);

  // Scan so that the winning bit is the last one written.
  always_comb begin
    found_c = 1'b0;
    idx_c   = '0;
    if (LSB_FIRST) begin
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
        if (vec[i]) begin
          found_c = 1'b1;
          idx_c   = IDX_W'(i);
        end
      end
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (vec[i]) begin
          found_c = 1'b1;
          idx_c   = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/spare_slot_allocator.sv
// Spare PE slot allocator: tracks free/allocated/faulty slots and grants the
// first available slot per request with registered outputs.
module spare_slot_allocator
  import bisr_pkg::*;
#(
  parameter  int unsigned NUM_SLOTS    = 16,
  parameter  int unsigned PRIORITY_LSB = 1,
  localparam int unsigned IDX_W        = idx_width(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_req,
  output logic                 alloc_gnt,
  output logic                 alloc_fail,
  output logic [IDX_W-1:0]     alloc_idx,
  input  logic                 release_valid,
  input  logic [IDX_W-1:0]     release_idx,
  input  logic                 fault_valid,
  input  logic [IDX_W-1:0]     fault_idx,
  output logic [NUM_SLOTS-1:0] alloc_map,
  output logic [NUM_SLOTS-1:0] fault_map,
  output logic [IDX_W:0]       free_count
);

  localparam int unsigned CNT_W = IDX_W + 1;

  logic                 fault_ok_c;
  logic                 release_ok_c;
  logic                 found_c;
  logic [IDX_W-1:0]     find_idx_c;
  logic [NUM_SLOTS-1:0] fault_set_c;
  logic [NUM_SLOTS-1:0] release_clr_c;
  logic [NUM_SLOTS-1:0] grant_set_c;
  logic [NUM_SLOTS-1:0] fault_next_c;
  logic [NUM_SLOTS-1:0] alloc_next_c;
  logic [NUM_SLOTS-1:0] avail_c;
  logic [CNT_W-1:0]     free_next_c;

  assign fault_ok_c   = fault_valid   && (32'(fault_idx)   < NUM_SLOTS);
  assign release_ok_c = release_valid && (32'(release_idx) < NUM_SLOTS);

  // Fault update first, so a slot faulted this cycle is excluded from the search.
  always_comb begin
    fault_set_c = '0;
    if (fault_ok_c) fault_set_c[fault_idx] = 1'b1;
    fault_next_c = fault_map | fault_set_c;
    avail_c = '0;
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      avail_c[i] = ({alloc_map[i], fault_next_c[i]} == SLOT_FREE);
    end
  end

  find_first_set #(
    .WIDTH     (NUM_SLOTS),
    .LSB_FIRST (PRIORITY_LSB != 0),
    .IDX_W     (IDX_W)
  ) u_find (
    .vec     (avail_c),
    .found_c (found_c),
    .idx_c   (find_idx_c)
  );

  // Grant sets the found slot; release only clears slots allocated before this
  // cycle, so a same-cycle grant is never undone and a FREE release is a no-op.
  always_comb begin
    grant_set_c   = '0;
    release_clr_c = '0;
    if (alloc_req && found_c) grant_set_c[find_idx_c] = 1'b1;
    if (release_ok_c) release_clr_c[release_idx] = 1'b1;
    alloc_next_c = (alloc_map & ~(release_clr_c & alloc_map)) | grant_set_c;
  end

  // Popcount of slots that will be free after this edge.
  always_comb begin
    free_next_c = '0;
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      if ({alloc_next_c[i], fault_next_c[i]} == SLOT_FREE) begin
        free_next_c = free_next_c + CNT_W'(1);
      end
    end
  end

  // Map and response registers; reset drops any request in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_map  <= '0;
      fault_map  <= '0;
      free_count <= CNT_W'(NUM_SLOTS);
      alloc_gnt  <= 1'b0;
      alloc_fail <= 1'b0;
      alloc_idx  <= '0;
    end else begin
      alloc_map  <= alloc_next_c;
      fault_map  <= fault_next_c;
      free_count <= free_next_c;
      alloc_gnt  <= alloc_req && found_c;
      alloc_fail <= alloc_req && !found_c;
      alloc_idx  <= (alloc_req && found_c) ? find_idx_c : '0;
    end
  end

endmodule
